// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : request size encodings (2'b11 behaves as a word)
//   state_t                 : control FSM states
//   is_misaligned()         : alignment check for a size/low-address pair
//   align_lo()              : low address bits with the misaligned part cleared
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Bytes are always aligned; anything that is not a byte or half is a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return addr_lo;
      SZ_HALF: return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   size, addr_lo  : access size and byte offset within the word
//   is_unsigned    : zero-extend sub-word loads instead of sign-extending
//   rdata          : word read from memory (load path)
//   old_word       : previously read word (store merge path)
//   wdata          : right-aligned store data
//   load_data      : extracted and extended load result
//   merged         : old_word with the addressed lane replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the memory stage and a word-addressed memory.
// Byte/half/word loads and stores; sub-word stores use read-modify-write.
//   clk, reset                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : request handshake (ready only in IDLE)
//   in_we, in_size, in_unsigned, in_addr, in_wdata : request fields
//   out_valid, out_rdata, out_err : one-cycle response
//   dm_addr, dm_wdata, dm_we, dm_re, dm_rdata : word memory port
// Optional feature macro LSU_MISALIGN_EXC_EN: misaligned requests skip memory
// and respond with out_err; otherwise they are force-aligned.
module lsu
  import lsu_pkg::*;
#(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic        dm_re,
  input  logic [31:0] dm_rdata
);

  localparam int AW = $clog2(DM_WORDS);

  state_t          state_reg, state_next;
  logic            we_reg;
  logic [1:0]      size_reg;
  logic            uns_reg;
  logic [AW+1:0]   addr_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     old_reg;
  logic [31:0]     result_reg;
  logic [31:0]     load_data;
  logic [31:0]     merged;
  logic            accept;
  logic            sub_word;

  // Address bits above the memory range wrap and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr[31:AW+2];

  assign accept   = in_valid && (state_reg == IDLE);
  assign sub_word = (size_reg == SZ_BYTE) || (size_reg == SZ_HALF);

`ifdef LSU_MISALIGN_EXC_EN
  logic req_mis;
  logic err_reg;
  assign req_mis = is_misaligned(in_size, in_addr[1:0]);
`endif

  lsu_align u_align (
    .size        (size_reg),
    .addr_lo     (addr_reg[1:0]),
    .is_unsigned (uns_reg),
    .rdata       (dm_rdata),
    .old_word    (old_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Strobes decode from state alone so a reset drops them asynchronously.
  always_comb begin
    state_next = state_reg;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_EXC_EN
          state_next = req_mis ? RESP : ACCESS;
`else
          state_next = ACCESS;
`endif
        end
      end
      ACCESS: begin
        if (we_reg && !sub_word) begin
          dm_we      = 1'b1;
          state_next = RESP;
        end else begin
          dm_re      = 1'b1;
          state_next = we_reg ? MERGE : RESP;
        end
      end
      MERGE: begin
        dm_we      = 1'b1;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_reg     <= 1'b0;
      size_reg   <= SZ_BYTE;
      uns_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      old_reg    <= '0;
      result_reg <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_reg     <= in_we;
        size_reg   <= in_size;
        uns_reg    <= in_unsigned;
        // Force-aligning is harmless when misaligned requests are trapped,
        // since those never touch memory.
        addr_reg   <= {in_addr[AW+1:2], align_lo(in_size, in_addr[1:0])};
        wdata_reg  <= in_wdata;
        result_reg <= '0;
`ifdef LSU_MISALIGN_EXC_EN
        err_reg    <= req_mis;
`endif
      end
      if (state_reg == ACCESS) begin
        if (we_reg) old_reg    <= dm_rdata;
        else        result_reg <= load_data;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == RESP);
  assign out_rdata = result_reg;
  assign dm_addr   = 32'(addr_reg[AW+1:2]);
  assign dm_wdata  = (state_reg == MERGE) ? merged : wdata_reg;

`ifdef LSU_MISALIGN_EXC_EN
  assign out_err = (state_reg == RESP) && err_reg;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu against a behavioural word memory.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_we = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic        in_unsigned = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic        dm_re;
  logic [31:0] dm_rdata;

  always #5 clk = ~clk;

  lsu #(.DM_WORDS(1024)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_we       (in_we),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .out_valid   (out_valid),
    .out_rdata   (out_rdata),
    .out_err     (out_err),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_we       (dm_we),
    .dm_re       (dm_re),
    .dm_rdata    (dm_rdata)
  );

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (dm_we) mem[dm_addr[9:0]] <= dm_wdata;
  assign dm_rdata = mem[dm_addr[9:0]];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_re;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int strobe_viol = 0;
  int resp_seen = 0;

  function automatic vec_t mk(logic we, logic [1:0] sz, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rd, logic err,
                              int lat, int nwe, int nre, logic chkm, logic [31:0] expm);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rd; v.exp_err = err; v.exp_lat = lat;
    v.exp_we = nwe; v.exp_re = nre; v.chk_mem = chkm; v.exp_mem = expm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle observed at the falling edge: strobe bookkeeping plus
  // scoreboard pop on every response.
  task automatic tick();
    resp_t e;
    @(negedge clk);
    if (dm_we) we_cnt++;
    if (dm_re) re_cnt++;
    if ((dm_we && dm_re) || ((dm_we || dm_re) && (in_ready || out_valid))) strobe_viol++;
    if (out_valid) begin
      resp_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_rdata", out_rdata, e.rdata);
        chk("resp_err", 32'(out_err), 32'(e.err));
      end
    end
    $display("cycle: state_ready=%0b we=%0b re=%0b addr=%h valid=%0b", in_ready, dm_we, dm_re, dm_addr, out_valid);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_we = v.we; in_size = v.size; in_unsigned = v.uns;
    in_addr = v.addr; in_wdata = v.wdata;
  endtask

  task automatic scramble();
    in_we = 1'($urandom); in_size = 2'($urandom); in_unsigned = 1'($urandom);
    in_addr = $urandom; in_wdata = $urandom;
  endtask

  task automatic do_req(input int idx, input vec_t v);
    resp_t e;
    int w0, r0, lat;
    tick();
    chk("ready_before", 32'(in_ready), 32'd1);
    drive(v);
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    w0 = we_cnt; r0 = re_cnt; lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lat++;
      if (out_valid) break;
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("we_cycles", 32'(we_cnt - w0), 32'(v.exp_we));
    chk("re_cycles", 32'(re_cnt - r0), 32'(v.exp_re));
    if (v.chk_mem) chk("mem_word4", mem[4], v.exp_mem);
    $display("txn %0d: we=%0b size=%0d addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
             idx, v.we, v.size, v.addr, v.wdata, out_rdata, out_err, lat);
  endtask

  initial begin
    resp_t e;
    // Reset state while reset is held low.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_re", 32'(dm_re), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 1, 0, 1, 32'h11223344));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h11223344, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hAA, 32'h0, 0, 3, 1, 1, 1, 32'h1122AA44));
    vecs.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h11, 32'h0, 32'h000000AA, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h8001, 32'h0, 0, 3, 1, 1, 1, 32'h8001AA44));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 32'h00008001, 0, 2, 0, 1, 0, 32'h0));
`ifdef LSU_MISALIGN_EXC_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0, 0, 32'h0));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h13, 32'h0, 32'h8001AA44, 0, 2, 0, 1, 0, 32'h0));
`endif
    vecs.push_back(mk(0, 2'b00, 0, 32'h10, 32'h0, 32'h00000044, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFAA44, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h13, 32'hFFFFFF7F, 32'h0, 0, 3, 1, 1, 1, 32'h7F01AA44));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 32'h0000007F, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h12, 32'h0, 32'h00000001, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h1010, 32'h0, 32'h7F01AA44, 0, 2, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 32'h7F01AA44, 0, 2, 0, 1, 0, 32'h0));
`ifdef LSU_MISALIGN_EXC_EN
    vecs.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0, 0, 32'h0));
`else
    vecs.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0, 32'h00007F01, 0, 2, 0, 1, 0, 32'h0));
`endif

    foreach (vecs[i]) do_req(i, vecs[i]);

    // Reset asserted during MERGE of sb 0x55 @0x10.
    tick();
    drive(mk(1, 2'b00, 0, 32'h10, 32'h55, 32'h0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    tick();
    tick();
    chk("merge_we", 32'(dm_we), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_we_drop", 32'(dm_we), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("abort_mem_word4", mem[4], 32'h7F01AA44);
    chk("abort_ready_after", 32'(in_ready), 32'd1);
    $display("txn abort: sb 55 @10 reset in MERGE, word4=%h", mem[4]);

    // Back-to-back with in_valid held high.
    tick();
    drive(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
    e.rdata = 32'h7F01AA44; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    drive(mk(1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0, 32'h0));
    e.rdata = 32'h0; e.err = 1'b0;
    sb_q.push_back(e);
    tick();
    chk("b2b_ready_access", 32'(in_ready), 32'd0);
    tick();
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_ready_resp", 32'(in_ready), 32'd0);
    tick();
    chk("b2b_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    tick();
    chk("b2b_dm_we", 32'(dm_we), 32'd1);
    chk("b2b_dm_addr", dm_addr, 32'd0);
    chk("b2b_dm_wdata", dm_wdata, 32'hDEADBEEF);
    tick();
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    tick();
    chk("b2b_mem_word0", mem[0], 32'hDEADBEEF);
    $display("txn b2b: lw @10 then sw DEADBEEF @1000, word0=%h", mem[0]);

    chk("strobe_rules", 32'(strobe_viol), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("responses_seen", 32'(resp_seen), 32'(vecs.size() + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
